term_write_ctrl: RTL and testbench

Cursor and scroll controller that owns the write port of the `vga_text_mode` character buffer. It accepts a byte stream, typically from `uart_rx`, over a valid/ready handshake. It interprets control codes, keeps the cursor position, and issues single-cycle writes to the 80x25 text RAM. Scrolling is done by rotating a row base (`scroll_row`) and blanking the newly exposed line, so existing text is never copied.

---
 rtl/term_write_ctrl_if.sv | 31 +++
 rtl/term_write_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_term_write_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_write_ctrl_if.sv
`timescale 1ns/1ps
// term_write_ctrl_if: byte-stream input handshake plus the text-RAM write port.
// The slave side belongs to the controller, the master side to its environment.
interface term_write_ctrl_if #(
   parameter int unsigned ADDR_W = 11
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );
endinterface

// File: rtl/term_write_ctrl.sv
`timescale 1ns/1ps
// term_write_ctrl: cursor/scroll controller owning the write port of the
// text-mode character buffer. Bytes arrive over a valid/ready handshake,
// printable ones are written at the cursor, control codes move the cursor.
// Scrolling rotates the physical row shown at the top (scroll_row) and
// blanks the newly exposed bottom line instead of copying text.
module term_write_ctrl #(
   parameter int unsigned COLS   = 80,
   parameter int unsigned ROWS   = 25,
   parameter int unsigned ADDR_W = 11,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic               clk100,
   input  logic               rst_n,
   term_write_ctrl_if.slave   bus,
   output logic [4:0]         scroll_row,
   output logic [4:0]         cursor_row,
   output logic [6:0]         cursor_col,
   output logic               busy
);

   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned CNT_W = $clog2(CELLS + 1);

   typedef enum logic [1:0] {
      CLR_ALL,
      IDLE,
      WRITE,
      CLR_LINE
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  clr_cnt, cnt_nx;
   logic [ADDR_W-1:0] line_base, base_nx;
   logic [ADDR_W-1:0] wr_addr_q, addr_nx;
   logic [7:0]        wr_data_q, data_nx;
   logic              wr_en_q, wr_en_nx;
   logic [4:0]        scroll_q, scroll_nx;
   logic [4:0]        row_q, row_nx;
   logic [6:0]        col_q, col_nx;

   logic              accept;
   logic              printable;
   logic              at_bottom;
   logic              lf;
   logic [5:0]        prow_sum;
   logic [4:0]        prow;
   logic [4:0]        scroll_inc;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] bottom_base;

   assign accept    = bus.in_valid && (state == IDLE);
   assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
   assign at_bottom = (row_q == 5'(ROWS - 1));

   // Logical cursor row mapped onto the rotated physical RAM row.
   assign prow_sum   = {1'b0, scroll_q} + {1'b0, row_q};
   assign prow       = (prow_sum >= 6'(ROWS)) ? 5'(prow_sum - 6'(ROWS)) : prow_sum[4:0];
   assign cur_addr   = ADDR_W'(prow * COLS + col_q);
   assign scroll_inc = (scroll_q == 5'(ROWS - 1)) ? '0 : scroll_q + 5'd1;

   // After scroll_row advances by one, the new bottom physical row is the
   // row that used to be at the top, i.e. the current scroll_row.
   assign bottom_base = ADDR_W'(scroll_q * COLS);

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLR_ALL;
         clr_cnt   <= '0;
         line_base <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         scroll_q  <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         state     <= state_nx;
         clr_cnt   <= cnt_nx;
         line_base <= base_nx;
         wr_en_q   <= wr_en_nx;
         wr_addr_q <= addr_nx;
         wr_data_q <= data_nx;
         scroll_q  <= scroll_nx;
         row_q     <= row_nx;
         col_q     <= col_nx;
      end
   end

   // Next-state, cursor and write-port logic. A line feed raised either by
   // an LF byte or by autowrap is handled once, after the state decode.
   always_comb begin
      state_nx  = state;
      cnt_nx    = clr_cnt;
      base_nx   = line_base;
      wr_en_nx  = 1'b0;
      addr_nx   = wr_addr_q;
      data_nx   = wr_data_q;
      scroll_nx = scroll_q;
      row_nx    = row_q;
      col_nx    = col_q;
      lf        = 1'b0;

      case (state)
         CLR_ALL: begin
            if (clr_cnt == CNT_W'(CELLS)) begin
               state_nx = IDLE;
            end else begin
               wr_en_nx = 1'b1;
               addr_nx  = ADDR_W'(clr_cnt);
               data_nx  = BLANK;
               cnt_nx   = clr_cnt + 1'b1;
            end
         end

         CLR_LINE: begin
            if (clr_cnt == CNT_W'(COLS)) begin
               state_nx = IDLE;
            end else begin
               wr_en_nx = 1'b1;
               addr_nx  = line_base + ADDR_W'(clr_cnt);
               data_nx  = BLANK;
               cnt_nx   = clr_cnt + 1'b1;
            end
         end

         IDLE: begin
            if (accept) begin
               if (printable) begin
                  state_nx = WRITE;
                  wr_en_nx = 1'b1;
                  addr_nx  = cur_addr;
                  data_nx  = bus.in_data;
               end else begin
                  case (bus.in_data)
                     8'h0A: lf = 1'b1;
                     8'h0D: col_nx = '0;
                     8'h08: if (col_q != '0) col_nx = col_q - 7'd1;
                     8'h0C: begin
                        row_nx    = '0;
                        col_nx    = '0;
                        scroll_nx = '0;
                        cnt_nx    = '0;
                        state_nx  = CLR_ALL;
                     end
                     default: ;
                  endcase
               end
            end
         end

         WRITE: begin
            state_nx = IDLE;
            if (col_q == 7'(COLS - 1)) begin
               col_nx = '0;
               lf     = 1'b1;
            end else begin
               col_nx = col_q + 7'd1;
            end
         end

         default: state_nx = CLR_ALL;
      endcase

      // The first blank of a line clear is issued in the same edge that
      // enters CLR_LINE, so the clear occupies exactly COLS cycles.
      if (lf) begin
         if (!at_bottom) begin
            row_nx = row_q + 5'd1;
         end else begin
            scroll_nx = scroll_inc;
            base_nx   = bottom_base;
            state_nx  = CLR_LINE;
            wr_en_nx  = 1'b1;
            addr_nx   = bottom_base;
            data_nx   = BLANK;
            cnt_nx    = CNT_W'(1);
         end
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign scroll_row   = scroll_q;
   assign cursor_row   = row_q;
   assign cursor_col   = col_q;
   assign busy         = (state == CLR_ALL) || (state == CLR_LINE);

endmodule

// File: tb/tb_term_write_ctrl.sv
`timescale 1ns/1ps
// tb_term_write_ctrl: randomized and directed byte streams against a
// screen-level reference model (cursor, scroll base, expected write list,
// expected stall length per accepted byte).
module tb_term_write_ctrl;

   localparam int COLS   = 80;
   localparam int ROWS   = 25;
   localparam int ADDR_W = 11;
   localparam logic [7:0] BLANK = 8'h20;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   logic       clk100 = 1'b0;
   logic       rst_n;
   logic [4:0] scroll_row, cursor_row;
   logic [6:0] cursor_col;
   logic       busy;

   term_write_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   term_write_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(BLANK)
   ) dut (
      .clk100(clk100), .rst_n(rst_n), .bus(bus),
      .scroll_row(scroll_row), .cursor_row(cursor_row),
      .cursor_col(cursor_col), .busy(busy)
   );

   always #5 clk100 = ~clk100;

   int  checks = 0, failures = 0;
   bit  chk_en = 1'b0;
   int  m_row = 0, m_col = 0, m_scroll = 0;
   int  prev_row = 0, prev_col = 0;
   wr_t exp_q[$];
   int  obs_log[$];
   bit  gap_pending = 1'b0, gap_first_write = 1'b0;
   int  gap_cnt = 0, exp_gap = 0;
   int  last_a = 0, last_d = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int log_at(input int i);
      if (i < 0 || i >= obs_log.size()) return -1;
      return obs_log[i];
   endfunction

   // ---------------- reference model ----------------
   task automatic push_blank_row(input int prow);
      for (int c = 0; c < COLS; c++) exp_q.push_back(wr_t'{a: ADDR_W'(prow * COLS + c), d: BLANK});
   endtask

   task automatic model_lf(output bit scrolled);
      scrolled = 1'b0;
      if (m_row < ROWS - 1) m_row++;
      else begin
         m_scroll = (m_scroll + 1) % ROWS;
         push_blank_row((m_scroll + ROWS - 1) % ROWS);  // new bottom line
         scrolled = 1'b1;
      end
   endtask

   task automatic model_accept(input logic [7:0] b);
      bit sc;
      prev_row = m_row; prev_col = m_col;
      gap_cnt = 0; gap_pending = 1'b1; gap_first_write = 1'b0; exp_gap = 0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         exp_q.push_back(wr_t'{a: ADDR_W'(((m_scroll + m_row) % ROWS) * COLS + m_col), d: b});
         gap_first_write = 1'b1;
         exp_gap = 1;
         if (m_col < COLS - 1) m_col++;
         else begin
            m_col = 0;
            model_lf(sc);
            if (sc) exp_gap += COLS;
         end
      end else if (b == 8'h0A) begin
         model_lf(sc);
         if (sc) exp_gap = COLS;
      end else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (b == 8'h0C) begin
         m_row = 0; m_col = 0; m_scroll = 0;
         for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back(wr_t'{a: ADDR_W'(i), d: BLANK});
         exp_gap = COLS * ROWS + 1;
      end
   endtask

   // Acceptance monitor feeds the model.
   always @(posedge clk100)
      if (rst_n && chk_en && bus.in_valid && bus.in_ready) model_accept(bus.in_data);

   // Per-cycle compare against the model.
   always @(negedge clk100) begin
      if (chk_en) begin
         if (bus.wr_en) begin
            if (exp_q.size() == 0) check("spurious write addr", int'(bus.wr_addr), -1);
            else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", int'(bus.wr_addr), int'(e.a));
               check("wr_data", int'(bus.wr_data), int'(e.d));
               last_a = int'(e.a); last_d = int'(e.d);
            end
            obs_log.push_back(int'(bus.wr_addr));
         end else begin
            check("hold wr_addr", int'(bus.wr_addr), last_a);
            check("hold wr_data", int'(bus.wr_data), last_d);
         end
         if (bus.in_ready) begin
            if (gap_pending) begin
               check("stall length", gap_cnt, exp_gap);
               gap_pending = 1'b0;
            end
            check("idle busy", int'(busy), 0);
            check("pending writes", exp_q.size(), 0);
            check("cursor_row", int'(cursor_row), m_row);
            check("cursor_col", int'(cursor_col), m_col);
            check("scroll_row", int'(scroll_row), m_scroll);
         end else begin
            check("stall expected", int'(gap_pending), 1);
            if (gap_first_write && gap_cnt == 0) begin
               check("write-cycle busy", int'(busy), 0);
               check("write-cycle row", int'(cursor_row), prev_row);
               check("write-cycle col", int'(cursor_col), prev_col);
            end else begin
               check("clear busy", int'(busy), 1);
            end
            gap_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk100);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 5000) begin
         @(negedge clk100);
         n++;
      end
      if (!bus.in_ready) begin
         check("send timeout", int'(bus.in_ready), 1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk100);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      @(negedge clk100);
      bus.in_valid = 1'b0;
      #1;
      while (!(bus.in_ready && !gap_pending && exp_q.size() == 0) && n < max) begin
         @(negedge clk100);
         #1;
         n++;
      end
      check("idle reached", int'(bus.in_ready && !gap_pending && exp_q.size() == 0), 1);
   endtask

   task automatic assert_reset;
      chk_en = 1'b0;
      gap_pending = 1'b0;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"}, int'(bus.in_ready), 0);
      check({tag, " wr_en"}, int'(bus.wr_en), 0);
      check({tag, " wr_addr"}, int'(bus.wr_addr), 0);
      check({tag, " wr_data"}, int'(bus.wr_data), 0);
      check({tag, " scroll_row"}, int'(scroll_row), 0);
      check({tag, " cursor_row"}, int'(cursor_row), 0);
      check({tag, " cursor_col"}, int'(cursor_col), 0);
      check({tag, " busy"}, int'(busy), 1);
   endtask

   task automatic release_reset;
      repeat (2) @(negedge clk100);
      m_row = 0; m_col = 0; m_scroll = 0;
      exp_q.delete();
      for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back(wr_t'{a: ADDR_W'(i), d: BLANK});
      last_a = 0; last_d = 0;
      rst_n = 1'b1;
      @(posedge clk100);
      gap_cnt = 0; exp_gap = COLS * ROWS; gap_first_write = 1'b0; gap_pending = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] b;
      int r;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rst_n = 1'b1;
      #1;
      assert_reset();
      check_reset_outputs("por");
      release_reset();
      wait_idle(3000);
      check("init in_ready", int'(bus.in_ready), 1);
      check("init cursor_row", int'(cursor_row), 0);
      check("init cursor_col", int'(cursor_col), 0);

      // "AB\r\nC"
      obs_log.delete();
      send_str("AB\r\nC");
      wait_idle(200);
      check("AB writes", obs_log.size(), 3);
      check("A addr", log_at(0), 0);
      check("B addr", log_at(1), 1);
      check("C addr", log_at(2), 80);
      check("AB row", int'(cursor_row), 1);
      check("AB col", int'(cursor_col), 1);
      check("AB scroll", int'(scroll_row), 0);

      // 81 'x' from home: wrap at col 79 without an extra write
      send_byte(8'h0C);
      wait_idle(3000);
      obs_log.delete();
      for (int i = 0; i < 81; i++) send_byte("x");
      wait_idle(200);
      check("wrap writes", obs_log.size(), 81);
      check("wrap col79 addr", log_at(79), 79);
      check("wrap last addr", log_at(80), 80);
      check("wrap row", int'(cursor_row), 1);
      check("wrap col", int'(cursor_col), 1);

      // Scroll from (24,5) with scroll_row 0
      send_byte(8'h0C);
      wait_idle(3000);
      for (int i = 0; i < 24; i++) send_byte(8'h0A);
      for (int i = 0; i < 5; i++) send_byte(" ");
      wait_idle(200);
      check("pre-scroll row", int'(cursor_row), 24);
      check("pre-scroll col", int'(cursor_col), 5);
      obs_log.delete();
      send_byte(8'h0A);
      wait_idle(200);
      check("scroll count", obs_log.size(), 80);
      check("scroll first", log_at(0), 0);
      check("scroll last", log_at(79), 79);
      check("scroll_row 1", int'(scroll_row), 1);
      check("scroll keeps row", int'(cursor_row), 24);
      check("scroll keeps col", int'(cursor_col), 5);
      obs_log.delete();
      send_byte("Z");
      wait_idle(50);
      check("Z addr", log_at(0), 5);

      // scroll_row 24, cursor (24,0): prow wraps
      for (int i = 0; i < 23; i++) send_byte(8'h0A);
      send_byte(8'h0D);
      wait_idle(3000);
      check("scroll_row 24", int'(scroll_row), 24);
      obs_log.delete();
      send_byte("Q");
      send_byte(8'h08);
      send_byte(8'h08);
      wait_idle(50);
      check("Q addr", log_at(0), 1840);
      check("BS no write", obs_log.size(), 1);
      check("BS col floor", int'(cursor_col), 0);

      // Randomized stream
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      b = 8'($urandom_range(32, 126));
         else if (r < 75) b = 8'h0A;
         else if (r < 80) b = 8'h0D;
         else if (r < 90) b = 8'h08;
         else if (r < 91) b = 8'h0C;
         else             b = 8'($urandom_range(128, 255));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk100);
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk100);
         end
         send_byte(b);
      end
      wait_idle(3000);

      // Reset in the middle of a line clear
      for (int i = 0; i < 25; i++) send_byte(8'h0A);
      wait_idle(3000);
      check("pre-reset row", int'(cursor_row), 24);
      send_byte(8'h0A);
      repeat (40) @(posedge clk100);
      #2;
      check("mid-clear busy", int'(busy), 1);
      assert_reset();
      check_reset_outputs("mid-clear rst");
      release_reset();
      wait_idle(3000);
      obs_log.delete();
      send_byte("A");
      wait_idle(50);
      check("post-reset A addr", log_at(0), 0);
      check("post-reset col", int'(cursor_col), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
